aoram_bridge: RTL

- SoC-side sequencer that drives the always-on RAM port (aoram_clkb/bcen/bwen/ba/bd) and consumes aoram_bq.
- Converts a simple valid/ready request channel into strobed single-word accesses on one of two 1Kx36 AO RAM banks.
- Returns read data or error on a valid/ready response channel.
- Honours ipsleep and AO isolation.

---
 rtl/aoram_bridge.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/aoram_bridge.sv
// aoram_bridge: turns a valid/ready request channel into strobed single-word
// accesses on one of two always-on RAM banks and returns data/error on a
// valid/ready response channel. All RAM-port outputs come straight from flops.
module aoram_bridge #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 1,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned DW         = 36
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [10:0]          req_addr,
    input  logic [DW-1:0]        req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    input  logic                 ipsleep,
    input  logic                 ao_iso,
    output logic                 busy,
    output logic [1:0]           aoram_clkb,
    output logic [1:0]           aoram_bcen,
    output logic [1:0]           aoram_bwen,
    output logic [9:0]           aoram_ba,
    output logic [DW-1:0]        aoram_bd,
    input  logic [1:0][DW-1:0]   aoram_bq
);

    // Counter reload values: a phase lasting N cycles loads N-1; 0 behaves as 1.
    localparam logic [3:0] SETUP_LD  = (SETUP_CYC  == 0) ? 4'd0 : 4'(SETUP_CYC  - 1);
    localparam logic [3:0] STROBE_LD = (STROBE_CYC == 0) ? 4'd0 : 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = (HOLD_CYC   == 0) ? 4'd0 : 4'(HOLD_CYC   - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;

    // Latched request attributes
    logic            r_bank;
    logic            r_we;
    logic            r_err_pend;

    // Registered RAM port
    logic [1:0]      r_clkb, r_bcen, r_bwen;
    logic [9:0]      r_ba;
    logic [DW-1:0]   r_bd;

    // Registered response
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [DW-1:0]   r_rsp_rdata;

    logic            w_accept, w_last, w_bank, w_we, w_err;
    logic [1:0]      w_sel, w_clkb_nxt, w_bcen_nxt, w_bwen_nxt;

    assign req_ready  = (r_state == IDLE) & ~ipsleep & ~reset;
    assign w_accept   = req_valid & req_ready;
    assign w_last     = (r_cnt == 4'd0);

    // In IDLE the strobes for SETUP are computed from the incoming request,
    // afterwards from the latched copy.
    assign w_bank     = (r_state == IDLE) ? req_addr[10] : r_bank;
    assign w_we       = (r_state == IDLE) ? req_we       : r_we;
    assign w_sel      = w_bank ? 2'b10 : 2'b01;

    // Isolation seen at any point of the RAM sequence turns the result into an error.
    assign w_err      = r_err_pend | ao_iso;

    assign busy       = (r_state != IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rsp_rdata;
    assign aoram_clkb = r_clkb;
    assign aoram_bcen = r_bcen;
    assign aoram_bwen = r_bwen;
    assign aoram_ba   = r_ba;
    assign aoram_bd   = r_bd;

    // State register and phase down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter reload and next values of the registered RAM strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
        w_clkb_nxt  = 2'b00;
        w_bcen_nxt  = 2'b11;
        w_bwen_nxt  = 2'b11;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (ao_iso) begin
                        w_state_nxt = RESP;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = SETUP;
                        w_cnt_nxt   = SETUP_LD;
                    end
                end
            end
            SETUP: begin
                if (w_last) begin
                    w_state_nxt = STROBE;
                    w_cnt_nxt   = STROBE_LD;
                end
            end
            STROBE: begin
                if (w_last) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end
            end
            HOLD: begin
                if (w_last) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 4'd0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Only the selected bank ever sees enable or strobe activity.
        if (w_state_nxt == SETUP || w_state_nxt == STROBE || w_state_nxt == HOLD) begin
            w_bcen_nxt = ~w_sel;
            w_bwen_nxt = w_we ? ~w_sel : 2'b11;
        end
        if (w_state_nxt == STROBE)
            w_clkb_nxt = w_sel;
    end

    // Request latch, RAM port registers and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank      <= 1'b0;
            r_we        <= 1'b0;
            r_err_pend  <= 1'b0;
            r_clkb      <= 2'b00;
            r_bcen      <= 2'b11;
            r_bwen      <= 2'b11;
            r_ba        <= '0;
            r_bd        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_clkb <= w_clkb_nxt;
            r_bcen <= w_bcen_nxt;
            r_bwen <= w_bwen_nxt;

            if (w_accept) begin
                r_bank     <= req_addr[10];
                r_we       <= req_we;
                r_err_pend <= 1'b0;
                if (ao_iso) begin
                    // Blocked at the door: answer straight away, RAM untouched.
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                end else begin
                    r_ba <= req_addr[9:0];
                    if (req_we)
                        r_bd <= req_wdata;
                end
            end

            if (r_state == SETUP || r_state == STROBE || r_state == HOLD)
                r_err_pend <= w_err;

            // Last HOLD cycle: read data is valid on aoram_bq, publish the response.
            if (r_state == HOLD && w_last) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (r_we | w_err) ? '0 : aoram_bq[r_bank];
            end

            if (r_state == RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

endmodule
